// File: rtl/mem_stream_sequencer.sv
// Frame sequencer: sweeps source RAM read addresses and delays each address to its destination write.
// Build macro MEM_SEQ_LOOP_EN enables seamless back-to-back frames while start is held.
module mem_stream_sequencer #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_SAMPLES = 256,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned PROC_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  input  logic [DATA_W-1:0] proc_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_we
);

  localparam int unsigned     PIPE_D   = RD_LAT + PROC_LAT;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     cnt;
  logic                issue, issue_last, loop_wrap, drain_empty;
  logic [PIPE_D-1:0]   pv, pl;
  logic [ADDR_W-1:0]   pa [PIPE_D];
  logic [DATA_W-1:0]   smp_hold, wr_hold;
  logic                done_q;

  assign issue      = (state == S_RUN);
  assign issue_last = issue && (cnt == LAST_IDX);

`ifdef MEM_SEQ_LOOP_EN
  assign loop_wrap = issue_last && start;
`else
  assign loop_wrap = 1'b0;
`endif

  // Stage 0 is refilled only by RUN, so the pipe is empty next cycle once
  // everything except the output stage is clear.
  generate
    if (PIPE_D > 1) begin : g_deep
      assign drain_empty = ~|pv[PIPE_D-2:0];
    end else begin : g_shallow
      assign drain_empty = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (issue_last && !loop_wrap) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if ((state == S_IDLE && start) || loop_wrap)
      cnt <= '0;
    else if (issue && !issue_last)
      cnt <= cnt + 1'b1;
  end

  // Address/valid/last-of-frame delay line; address stages only load on valid
  // so wr_addr naturally holds the last written index.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pl <= '0;
      for (int unsigned i = 0; i < PIPE_D; i++) pa[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < PIPE_D; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
        if (pv[i-1]) pa[i] <= pa[i-1];
      end
      pv[0] <= issue;
      pl[0] <= issue_last;
      if (issue) pa[0] <= cnt[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_hold <= '0;
      wr_hold  <= '0;
      done_q   <= 1'b0;
    end else begin
      if (smp_valid) smp_hold <= rd_data;
      if (wr_we)     wr_hold  <= proc_data;
      done_q <= wr_we && pl[PIPE_D-1];
    end
  end

  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = done_q;
  assign rd_addr   = cnt[ADDR_W-1:0];
  assign smp_valid = pv[RD_LAT-1];
  assign smp_data  = smp_valid ? rd_data : smp_hold;
  assign wr_we     = pv[PIPE_D-1];
  assign wr_addr   = pa[PIPE_D-1];
  assign wr_data   = wr_we ? proc_data : wr_hold;

endmodule
